// File: rtl/alu_ctrl_encoder_if.sv
// Handshake and control-word bundle between the instruction source, the ALU
// control encoder and the downstream ALU stage.
interface alu_ctrl_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  alu_fun;
   logic        sign;
   logic [1:0]  src_a;
   logic [1:0]  src_b;
   logic        illegal;
   logic        err_sticky;

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, alu_fun, sign, src_a, src_b, illegal, err_sticky
   );

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, alu_fun, sign, src_a, src_b, illegal, err_sticky
   );
endinterface

// File: rtl/alu_ctrl_encoder.sv
// MIPS instruction -> ALU control word encoder behind a 2-entry skid buffer.
// Define ALU_ENC_ILLEGAL_TRAP_EN to flag illegal instructions and keep a sticky error.
module alu_ctrl_encoder (
   input logic              clk,
   input logic              reset,
   alu_ctrl_encoder_if.slave bus
);

   localparam logic [5:0] F_ADD = 6'b000000;
   localparam logic [5:0] F_SUB = 6'b000001;
   localparam logic [5:0] F_AND = 6'b011000;
   localparam logic [5:0] F_OR  = 6'b011110;
   localparam logic [5:0] F_XOR = 6'b010110;
   localparam logic [5:0] F_NOR = 6'b010001;
   localparam logic [5:0] F_SLL = 6'b100000;
   localparam logic [5:0] F_SRL = 6'b100001;
   localparam logic [5:0] F_SRA = 6'b100011;
   localparam logic [5:0] F_EQ  = 6'b110011;
   localparam logic [5:0] F_NE  = 6'b110001;
   localparam logic [5:0] F_LT  = 6'b110101;
   localparam logic [5:0] F_LEZ = 6'b111101;
   localparam logic [5:0] F_LTZ = 6'b111011;
   localparam logic [5:0] F_GTZ = 6'b111111;

`ifdef ALU_ENC_ILLEGAL_TRAP_EN
   typedef struct packed {
      logic [5:0] alu_fun;
      logic       sign;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t ILLEGAL_WORD = '{alu_fun: F_ADD, sign: 1'b0, src_a: 2'd0, src_b: 2'd0, illegal: 1'b1};
`else
   typedef struct packed {
      logic [5:0] alu_fun;
      logic       sign;
      logic [1:0] src_a;
      logic [1:0] src_b;
   } ctrl_t;

   // Unsupported instructions degrade to an unsigned rs+rt add (NOP).
   localparam ctrl_t ILLEGAL_WORD = '{alu_fun: F_ADD, sign: 1'b0, src_a: 2'd0, src_b: 2'd0};
`endif

   function automatic ctrl_t word(input logic [5:0] f, input logic s,
                                  input logic [1:0] a, input logic [1:0] b);
      ctrl_t w;
      w         = ILLEGAL_WORD;
      w.alu_fun = f;
      w.sign    = s;
      w.src_a   = a;
      w.src_b   = b;
`ifdef ALU_ENC_ILLEGAL_TRAP_EN
      w.illegal = 1'b0;
`endif
      return w;
   endfunction

   logic [5:0] opcode;
   logic [4:0] rt;
   logic [5:0] funct;
   logic       unused_bits;
   ctrl_t      dec;

   assign opcode      = bus.instr[31:26];
   assign rt          = bus.instr[20:16];
   assign funct       = bus.instr[5:0];
   assign unused_bits = ^{bus.instr[25:21], bus.instr[15:6]};

   // NOTE: dec gets its default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      dec = ILLEGAL_WORD;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20:   dec = word(F_ADD, 1'b1, 2'd0, 2'd0);
               6'h21:   dec = word(F_ADD, 1'b0, 2'd0, 2'd0);
               6'h22:   dec = word(F_SUB, 1'b1, 2'd0, 2'd0);
               6'h23:   dec = word(F_SUB, 1'b0, 2'd0, 2'd0);
               6'h24:   dec = word(F_AND, 1'b0, 2'd0, 2'd0);
               6'h25:   dec = word(F_OR,  1'b0, 2'd0, 2'd0);
               6'h26:   dec = word(F_XOR, 1'b0, 2'd0, 2'd0);
               6'h27:   dec = word(F_NOR, 1'b0, 2'd0, 2'd0);
               6'h2A:   dec = word(F_LT,  1'b1, 2'd0, 2'd0);
               6'h2B:   dec = word(F_LT,  1'b0, 2'd0, 2'd0);
               6'h00:   dec = word(F_SLL, 1'b0, 2'd1, 2'd0);
               6'h02:   dec = word(F_SRL, 1'b0, 2'd1, 2'd0);
               6'h03:   dec = word(F_SRA, 1'b0, 2'd1, 2'd0);
               default: dec = ILLEGAL_WORD;
            endcase
         end
         6'h08:   dec = word(F_ADD, 1'b1, 2'd0, 2'd1);
         6'h09:   dec = word(F_ADD, 1'b0, 2'd0, 2'd1);
         6'h0A:   dec = word(F_LT,  1'b1, 2'd0, 2'd1);
         6'h0B:   dec = word(F_LT,  1'b0, 2'd0, 2'd1);
         6'h0C:   dec = word(F_AND, 1'b0, 2'd0, 2'd2);
         6'h0D:   dec = word(F_OR,  1'b0, 2'd0, 2'd2);
         6'h0E:   dec = word(F_XOR, 1'b0, 2'd0, 2'd2);
         // lui: the immediate is shifted left by a constant 16.
         6'h0F:   dec = word(F_SLL, 1'b0, 2'd2, 2'd2);
         6'h23,
         6'h2B:   dec = word(F_ADD, 1'b1, 2'd0, 2'd1);
         6'h04:   dec = word(F_EQ,  1'b1, 2'd0, 2'd0);
         6'h05:   dec = word(F_NE,  1'b1, 2'd0, 2'd0);
         6'h06:   dec = word(F_LEZ, 1'b1, 2'd0, 2'd0);
         6'h07:   dec = word(F_GTZ, 1'b1, 2'd0, 2'd0);
         6'h01:   if (rt == 5'd0) dec = word(F_LTZ, 1'b1, 2'd0, 2'd0);
         default: dec = ILLEGAL_WORD;
      endcase
   end

   // Two-slot circular buffer; in_ready is a flop so out_ready never reaches it combinationally.
   ctrl_t      mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic [1:0] count_nxt;
   logic       in_ready_q;
   logic       push;
   logic       pop;
   ctrl_t      head;

   assign push = bus.in_valid & in_ready_q;
   assign pop  = (count != 2'd0) & bus.out_ready;
   assign head = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   // NOTE: the two slots are reset because they drive the outputs directly and must read zero in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem[0]     <= '0;
         mem[1]     <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count      <= count_nxt;
         in_ready_q <= (count_nxt != 2'd2);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (count != 2'd0);
   assign bus.alu_fun   = head.alu_fun;
   assign bus.sign      = head.sign;
   assign bus.src_a     = head.src_a;
   assign bus.src_b     = head.src_b;

`ifdef ALU_ENC_ILLEGAL_TRAP_EN
   logic err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  err_q <= 1'b0;
      else if (pop && head.illegal) err_q <= 1'b1;
   end

   assign bus.illegal    = head.illegal;
   assign bus.err_sticky = err_q;
`else
   assign bus.illegal    = 1'b0;
   assign bus.err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Self-checking bench for alu_ctrl_encoder: directed scenarios plus randomized
// traffic against a table-driven decode model and a FIFO scoreboard.
module tb_alu_ctrl_encoder;

   localparam logic [5:0] C_ADD = 6'b000000, C_SUB = 6'b000001, C_AND = 6'b011000,
                          C_OR  = 6'b011110, C_XOR = 6'b010110, C_NOR = 6'b010001,
                          C_SLL = 6'b100000, C_SRL = 6'b100001, C_SRA = 6'b100011,
                          C_EQ  = 6'b110011, C_NE  = 6'b110001, C_LT  = 6'b110101,
                          C_LEZ = 6'b111101, C_LTZ = 6'b111011, C_GTZ = 6'b111111;

`ifdef ALU_ENC_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct packed {
      logic [5:0] op;
      logic       fn_any;
      logic [5:0] fn;
      logic       rt_zero;
      logic [5:0] code;
      logic       s;
      logic [1:0] a;
      logic [1:0] b;
   } row_t;

   typedef struct packed {
      logic [5:0] code;
      logic       s;
      logic [1:0] a;
      logic [1:0] b;
      logic       ill;
   } exp_t;

   logic clk;
   logic reset;
   alu_ctrl_encoder_if bus ();

   alu_ctrl_encoder dut (.clk(clk), .reset(reset), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_cmp;
   int   n_bad;
   row_t tbl[$];
   exp_t exp_q[$];
   bit   exp_err;
   bit   rdy_en;

   function automatic row_t mk(input logic [5:0] op, input int fn, input logic [5:0] code,
                               input bit s, input int a, input int b, input bit rtz);
      row_t r;
      r.op      = op;
      r.fn_any  = (fn < 0);
      r.fn      = (fn < 0) ? 6'd0 : 6'(fn);
      r.rt_zero = rtz;
      r.code    = code;
      r.s       = s;
      r.a       = 2'(a);
      r.b       = 2'(b);
      return r;
   endfunction

   task automatic build_table;
      tbl.push_back(mk(6'h00, 'h20, C_ADD, 1, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h21, C_ADD, 0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h22, C_SUB, 1, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h23, C_SUB, 0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h24, C_AND, 0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h25, C_OR,  0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h26, C_XOR, 0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h27, C_NOR, 0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h2A, C_LT,  1, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h2B, C_LT,  0, 0, 0, 0));
      tbl.push_back(mk(6'h00, 'h00, C_SLL, 0, 1, 0, 0));
      tbl.push_back(mk(6'h00, 'h02, C_SRL, 0, 1, 0, 0));
      tbl.push_back(mk(6'h00, 'h03, C_SRA, 0, 1, 0, 0));
      tbl.push_back(mk(6'h08, -1, C_ADD, 1, 0, 1, 0));
      tbl.push_back(mk(6'h09, -1, C_ADD, 0, 0, 1, 0));
      tbl.push_back(mk(6'h0A, -1, C_LT,  1, 0, 1, 0));
      tbl.push_back(mk(6'h0B, -1, C_LT,  0, 0, 1, 0));
      tbl.push_back(mk(6'h0C, -1, C_AND, 0, 0, 2, 0));
      tbl.push_back(mk(6'h0D, -1, C_OR,  0, 0, 2, 0));
      tbl.push_back(mk(6'h0E, -1, C_XOR, 0, 0, 2, 0));
      tbl.push_back(mk(6'h0F, -1, C_SLL, 0, 2, 2, 0));
      tbl.push_back(mk(6'h23, -1, C_ADD, 1, 0, 1, 0));
      tbl.push_back(mk(6'h2B, -1, C_ADD, 1, 0, 1, 0));
      tbl.push_back(mk(6'h04, -1, C_EQ,  1, 0, 0, 0));
      tbl.push_back(mk(6'h05, -1, C_NE,  1, 0, 0, 0));
      tbl.push_back(mk(6'h06, -1, C_LEZ, 1, 0, 0, 0));
      tbl.push_back(mk(6'h07, -1, C_GTZ, 1, 0, 0, 0));
      tbl.push_back(mk(6'h01, -1, C_LTZ, 1, 0, 0, 1));
   endtask

   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t e;
      e     = '0;
      e.ill = TRAP;
      foreach (tbl[i]) begin
         if (ins[31:26] == tbl[i].op && (tbl[i].fn_any || ins[5:0] == tbl[i].fn) &&
             (!tbl[i].rt_zero || ins[20:16] == 5'd0))
            e = {tbl[i].code, tbl[i].s, tbl[i].a, tbl[i].b, 1'b0};
      end
      return e;
   endfunction

   // Apply inputs for one clock, advance the scoreboard, and return at the next falling edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic rdy);
      bit   do_push;
      bit   do_pop;
      exp_t e;
      bus.in_valid  = v;
      bus.instr     = ins;
      bus.out_ready = rdy;
      do_push = v && rdy_en && exp_q.size() < 2;
      do_pop  = rdy && exp_q.size() != 0;
      if (do_pop) begin
         e = exp_q.pop_front();
         if (e.ill) exp_err = 1'b1;
      end
      if (do_push) exp_q.push_back(ref_decode(ins));
      @(negedge clk);
      if (reset) rdy_en = 1'b1;
   endtask

   function automatic logic [10:0] obs_word();
      return {bus.alu_fun, bus.sign, bus.src_a, bus.src_b};
   endfunction

   task automatic test_reset;
      logic [14:0] all_out;
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      all_out = {bus.in_ready, bus.out_valid, bus.alu_fun, bus.sign, bus.src_a, bus.src_b,
                 bus.illegal, bus.err_sticky};
      n_cmp++;
      if (all_out !== 15'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h expected 0000", all_out);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL ready_before_edge: got %b expected 0", bus.in_ready);
      end
      @(negedge clk);
      rdy_en = 1'b1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL ready_after_edge: got %b expected 1", bus.in_ready);
      end
   endtask

   task automatic test_add;
      step(1'b1, 32'h0085_1020, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || obs_word() !== {C_ADD, 1'b1, 2'd0, 2'd0}) begin
         n_bad++; $display("FAIL add_latency: got v=%b w=%h expected v=1 w=%h",
                           bus.out_valid, obs_word(), {C_ADD, 1'b1, 2'd0, 2'd0});
      end
      step(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL add_drain: got out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_lui_sra;
      step(1'b1, 32'h3C01_1234, 1'b0);
      n_cmp++;
      if (obs_word() !== {C_SLL, 1'b0, 2'd2, 2'd2}) begin
         n_bad++; $display("FAIL lui: got %h expected %h", obs_word(), {C_SLL, 1'b0, 2'd2, 2'd2});
      end
      step(1'b1, 32'h0002_1883, 1'b1);
      n_cmp++;
      if (obs_word() !== {C_SRA, 1'b0, 2'd1, 2'd0}) begin
         n_bad++; $display("FAIL sra: got %h expected %h", obs_word(), {C_SRA, 1'b0, 2'd1, 2'd0});
      end
      step(1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_backpressure;
      logic [10:0] w_eq, w_lt, w_or;
      w_eq = {C_EQ, 1'b1, 2'd0, 2'd0};
      w_lt = {C_LT, 1'b1, 2'd0, 2'd1};
      w_or = {C_OR, 1'b0, 2'd0, 2'd2};
      step(1'b1, 32'h1085_0003, 1'b0);
      step(1'b1, 32'h2882_FFFF, 1'b0);
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL full_ready: got %b expected 0", bus.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h3442_0001, 1'b0);
         n_cmp++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || obs_word() !== w_eq) begin
            n_bad++; $display("FAIL stall_hold: got rdy=%b v=%b w=%h expected rdy=0 v=1 w=%h",
                              bus.in_ready, bus.out_valid, obs_word(), w_eq);
         end
      end
      step(1'b1, 32'h3442_0001, 1'b1);
      n_cmp++;
      if (obs_word() !== w_lt || bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL release_second: got w=%h rdy=%b expected w=%h rdy=1",
                           obs_word(), bus.in_ready, w_lt);
      end
      step(1'b1, 32'h3442_0001, 1'b1);
      n_cmp++;
      if (obs_word() !== w_or || bus.out_valid !== 1'b1) begin
         n_bad++; $display("FAIL release_third: got w=%h v=%b expected w=%h v=1",
                           obs_word(), bus.out_valid, w_or);
      end
      step(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL release_empty: got out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, (i % 2 == 0) ? 32'h0085_1022 : 32'h0085_1023, 1'b1);
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.alu_fun !== C_SUB ||
             bus.sign !== (i % 2 == 0)) begin
            n_bad++; $display("FAIL stream_%0d: got v=%b rdy=%b fun=%b s=%b expected v=1 rdy=1 fun=%b s=%b",
                              i, bus.out_valid, bus.in_ready, bus.alu_fun, bus.sign, C_SUB, (i % 2 == 0));
         end
      end
      step(1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_illegal;
      step(1'b1, 32'hFC00_0000, 1'b1);
      n_cmp++;
      if (obs_word() !== {C_ADD, 1'b0, 2'd0, 2'd0} || bus.illegal !== TRAP || bus.err_sticky !== 1'b0) begin
         n_bad++; $display("FAIL illegal_word: got w=%h ill=%b err=%b expected w=%h ill=%b err=0",
                           obs_word(), bus.illegal, bus.err_sticky, {C_ADD, 1'b0, 2'd0, 2'd0}, TRAP);
      end
      step(1'b1, 32'h0085_1020, 1'b1);
      n_cmp++;
      if (bus.err_sticky !== TRAP || bus.illegal !== 1'b0) begin
         n_bad++; $display("FAIL illegal_sticky: got err=%b ill=%b expected err=%b ill=0",
                           bus.err_sticky, bus.illegal, TRAP);
      end
      step(1'b1, 32'h0085_1022, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (bus.err_sticky !== TRAP) begin
         n_bad++; $display("FAIL illegal_held: got err=%b expected %b", bus.err_sticky, TRAP);
      end
   endtask

   task automatic test_midreset;
      step(1'b1, 32'h0085_1020, 1'b0);
      step(1'b1, 32'h3442_0001, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      exp_q.delete();
      exp_err = 1'b0;
      rdy_en  = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.err_sticky !== 1'b0) begin
         n_bad++; $display("FAIL midreset_now: got v=%b rdy=%b err=%b expected 0 0 0",
                           bus.out_valid, bus.in_ready, bus.err_sticky);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1);
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_stale_%0d: got out_valid=%b expected 0", i, bus.out_valid);
         end
      end
      step(1'b1, 32'h0085_1024, 1'b0);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || obs_word() !== {C_AND, 1'b0, 2'd0, 2'd0}) begin
         n_bad++; $display("FAIL midreset_fresh: got v=%b w=%h expected v=1 w=%h",
                           bus.out_valid, obs_word(), {C_AND, 1'b0, 2'd0, 2'd0});
      end
      step(1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_random;
      logic [31:0] ins;
      row_t        r;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(4) == 0) begin
            ins = $urandom;
         end else begin
            r   = tbl[$urandom_range(tbl.size() - 1)];
            ins = $urandom;
            ins[31:26] = r.op;
            if (!r.fn_any) ins[5:0] = r.fn;
            if (r.rt_zero && $urandom_range(3) != 0) ins[20:16] = 5'd0;
         end
         step($urandom_range(3) != 0, ins, $urandom_range(2) != 0);
         n_cmp++;
         if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== (exp_q.size() < 2) ||
             bus.err_sticky !== exp_err) begin
            n_bad++; $display("FAIL rand_flags_%0d: got v=%b rdy=%b err=%b expected v=%b rdy=%b err=%b",
                              n, bus.out_valid, bus.in_ready, bus.err_sticky,
                              exp_q.size() != 0, exp_q.size() < 2, exp_err);
         end
         if (exp_q.size() != 0) begin
            n_cmp++;
            if ({obs_word(), bus.illegal} !== exp_q[0]) begin
               n_bad++; $display("FAIL rand_word_%0d: got %h expected %h", n, {obs_word(), bus.illegal}, exp_q[0]);
            end
         end
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      exp_err = 1'b0;
      rdy_en  = 1'b0;
      build_table();
      test_reset();
      test_add();
      test_lui_sra();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_encoder.md
ALU_CTRL_ENCODER -- requirements
Module: alu_ctrl_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  instruction word offered.
REQ-004 in_ready  output  1  encoder can accept; transfer when in_valid & in_ready at clk edge.
REQ-005 instr  input  32  MIPS instruction word; opcode [31:26], rt [20:16], shamt [10:6], funct [5:0].
REQ-006 out_valid  output  1  decoded control word available.
REQ-007 out_ready  input  1  downstream ALU stage accepts; transfer when out_valid & out_ready.
REQ-008 alu_fun  output  6  ALU function code, as encoded in REQ-014.
REQ-009 sign  output  1  signed-arithmetic select for the ALU.
REQ-010 src_a  output  2  A operand: 0 = rs, 1 = shamt zero-extended, 2 = constant 16.
REQ-011 src_b  output  2  B operand: 0 = rt, 1 = imm sign-extended, 2 = imm zero-extended.
REQ-012 illegal  output  1  current output word came from an unsupported instruction.
REQ-013 err_sticky  output  1  set on first illegal output transfer; cleared only by reset.

Function
REQ-014 The ALU function codes SHALL be: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NE 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-015 For opcode 0, funct SHALL map as follows, with src_a=0 and src_b=0 unless stated: 20 ADD s1, 21 ADD s0, 22 SUB s1, 23 SUB s0, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A LT s1, 2B LT s0, 00 SLL src_a=1, 02 SRL src_a=1, 03 SRA src_a=1.
REQ-016 The immediate opcodes SHALL map as follows: 08 ADD s1 b1, 09 ADD s0 b1, 0A LT s1 b1, 0B LT s0 b1, 0C AND b2, 0D OR b2, 0E XOR b2, 0F SLL a2 b2, 23/2B ADD s1 b1.
REQ-017 The branch opcodes SHALL map as follows, with src_b=0: 04 EQ s1, 05 NE s1, 06 LEZ s1, 07 GTZ s1, 01 with rt=0 LTZ s1.
REQ-018 Logic, shift and sign-irrelevant encodings SHALL drive sign=0.
REQ-019 Any other opcode/funct/rt combination SHALL be illegal (REQ-030).
REQ-020 Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output is empty.
REQ-021 Decode SHALL be registered through a 2-entry skid buffer.
REQ-022 in_ready SHALL be 1 whenever fewer than 2 entries are held; it SHALL be registered (no combinational path from out_ready).
REQ-023 Simultaneous input and output transfer SHALL keep occupancy unchanged and preserve order.
REQ-024 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-025 When full (2 entries), in_ready=0 and instr SHALL be ignored.
REQ-026 The buffer SHALL deliver words in strict FIFO order with no loss or duplication.

Reset
REQ-027 While reset=0: in_ready=0, out_valid=0, alu_fun=000000, sign=0, src_a=0, src_b=0, illegal=0, err_sticky=0, buffer empty.
REQ-028 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered entries immediately, with no partial output.

Configuration
REQ-030 Macro ALU_ENC_ILLEGAL_TRAP_EN defined: an illegal instruction SHALL yield alu_fun=000000, sign=0, src_a=0, src_b=0, illegal=1; err_sticky SHALL set on its output transfer.
REQ-031 Macro undefined: an illegal instruction SHALL decode as ADD s0 a0 b0 (NOP) with illegal=0; err_sticky SHALL be tied 0 and no illegal flag storage SHALL exist.

Verification
REQ-032 Reset release, then instr=0x00851020 (add) with out_ready=1 -> next cycle out_valid=1, alu_fun=000000, sign=1, src_a=0, src_b=0.
REQ-033 instr=0x3C011234 (lui) -> alu_fun=100000, src_a=2, src_b=2, sign=0; instr=0x00021883 (sra) -> alu_fun=100011, src_a=1.
REQ-034 Hold out_ready=0 and offer 3 words (beq 0x10850003, slti 0x2882FFFF, ori 0x34420001) -> in_ready=0 after 2 accepted, outputs stable at EQ; release -> EQ, LT s1 b1, then OR b2 in order.
REQ-035 Streaming sub/subu pairs with in_valid=out_ready=1 every cycle -> one output per cycle, alu_fun=000001 with sign alternating 1/0, in_ready never 0.
REQ-036 Illegal instr=0xFC000000 with ALU_ENC_ILLEGAL_TRAP_EN defined -> illegal=1, err_sticky=1 after transfer and held through later legal words; same stimulus without the macro -> NOP word, illegal=0, err_sticky=0.
REQ-037 Assert reset with 2 entries buffered -> out_valid=0 and in_ready=0 immediately; after release, no stale words appear.
